riscv_mem_lsu: RTL
==================

# riscv_mem_lsu

Parametrised memory stage for the RISC-V core pipeline, between EX and WB. It accepts one operation per handshake from EX and issues aligned loads/stores on the data bus interface. The bus may insert any number of wait states. Load data is lane-shifted and sign/zero-extended, misaligned accesses are trapped without touching the bus, and each result is held until WB accepts it.

## Interface
- XLEN, 32: datapath/address width, 32 or 64; STRB_W = XLEN/8 (derived, not overridable)
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- ds_rdy  in  1  EX presents a valid operation
- ds_ack  out  1  MEM accepts the operation this cycle
- ex_mem_result  in  XLEN  effective address (load/store) or ALU result (NOP)
- ex_mem_op  in  2  00 NOP, 01 LOAD, 10 STORE, 11 treated as NOP
- ex_mem_size  in  2  0 byte, 1 half, 2 word, 3 dword
- ex_mem_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
- ex_mem_data  in  XLEN  store data, right-justified
- ex_mem_wb_rsd  in  5  destination register
- us_rdy  out  1  result valid for WB
- us_ack  in  1  WB accepts result
- data_bif_addr  out  XLEN  byte address
- data_bif_req  out  1  bus request
- data_bif_rnw  out  1  1 = read, 0 = write
- data_bif_wmask  out  STRB_W  byte enables (writes only, 0 on reads)
- data_bif_wdata  out  XLEN  lane-aligned write data
- data_bif_ack  in  1  bus completes request (rdata valid on reads)
- data_bif_rdata  in  XLEN  read data, full bus word
- mem_wb_data  out  XLEN  load data / ALU result / faulting address
- mem_wb_rsd  out  5  destination register
- mem_wb_load  out  1  mem_wb_data is load data
- mem_wb_exc  out  1  misaligned/illegal access; mem_wb_data = address

## Operation
- All outputs are registered except ds_ack.
- Reset value of every output is 0. The state machine resets to IDLE.
- States:
  - IDLE: no operation held.
  - BUS: request outstanding.
  - HOLD: result presented to WB.
- ds_ack = (state==IDLE) | (state==HOLD & us_ack). A transfer occurs on ds_rdy & ds_ack.
- Alignment:
  - off = addr[log2(STRB_W)-1:0].
  - An access is misaligned when off is not a multiple of 2^size.
  - size 3 with XLEN=32 is illegal.
- Accept, by operation type:
  - NOP: -> HOLD with mem_wb_data = ex_mem_result, load=0, exc=0.
  - Misaligned/illegal LOAD/STORE: -> HOLD with exc=1, mem_wb_data = address, load=0. No bus request.
  - Aligned LOAD/STORE: -> BUS.
    - Register addr, req=1, rnw.
    - wmask = ((1<<2^size)-1) << off.
    - wdata = ex_mem_data << 8*off.
    - Latch rsd/size/unsigned.
- BUS: all bus outputs stay stable until data_bif_ack. On ack:
  - req goes to 0 next cycle; -> HOLD.
  - Load: mem_wb_data = extend(rdata >> 8*off, size, unsigned), load=1.
  - Store: mem_wb_data = 0, load=0.
- HOLD: us_rdy=1 and all mem_wb_* stable until us_ack.
  - On us_ack with a new accept: go to the state for the new operation; us_rdy stays 1 only if that is HOLD.
  - On us_ack otherwise: -> IDLE.
- data_bif_ack outside BUS is ignored.
- Sign extension is from bit 8·2^size−1. For XLEN=32, a word load ignores ex_mem_unsigned.

## Timing
- NOP/exception accepted in cycle N: us_rdy=1 in N+1.
- Bus op accepted in N: req=1 in N+1. If ack arrives in cycle N+1+k (k≥0), us_rdy=1 in N+2+k and req=0 in N+2+k.
- Back-to-back NOP/exception: one per cycle while us_ack is held high.
- Bus ops sustain one per 2 cycles with zero wait states.
- Reset mid-BUS: req drops asynchronously, the transaction is abandoned, and no result is produced.

## Test plan
- XLEN=32, LOAD size 0, addr 0x1003, signed, rdata 0x80_12_34_56, ack in the req cycle -> req 1 cycle later, mem_wb_data 0xFFFFFF80, load=1, us_rdy 2 cycles after accept.
- STORE size 1, addr 0x2002, data 0x0000ABCD -> wmask 4'b1100, wdata 0xABCD0000, rnw=0. With 3 wait states, req is held with stable fields for 4 cycles; result has load=0.
- LOAD size 2, addr 0x1001 -> exc=1, mem_wb_data 0x1001, req never asserted, us_rdy next cycle.
- Stream of 4 NOPs with us_ack=1 -> ds_ack high every cycle, results in order one per cycle. With us_ack=0 in HOLD -> ds_ack=0 and mem_wb_* stable.
- XLEN=64, LWU addr 0x…4, rdata 0xF0000000_00000000 -> mem_wb_data 0x00000000_F0000000. Same access with signed -> 0xFFFFFFFF_F0000000.
- rstn asserted while in BUS with req=1 -> req/us_rdy 0 immediately. After release, state is IDLE and ds_ack=1.

Source files
------------

// File: rtl/riscv_mem_lsu_if.sv
// Data bus between the memory stage and the data memory.
// The LSU drives the request side; the memory answers with ack/rdata.
interface riscv_mem_lsu_if #(
  parameter int XLEN = 32
);
  localparam int STRB_W = XLEN / 8;

  logic [XLEN-1:0]   addr;
  logic              req;
  logic              rnw;
  logic [STRB_W-1:0] wmask;
  logic [XLEN-1:0]   wdata;
  logic              ack;
  logic [XLEN-1:0]   rdata;

  modport master (
    output addr, req, rnw, wmask, wdata,
    input  ack, rdata
  );

  modport slave (
    input  addr, req, rnw, wmask, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/riscv_mem_lsu.sv
// Memory stage: one op per handshake, aligned bus access,
// load lane extraction/extension, misalignment trap, held result.
module riscv_mem_lsu #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ds_rdy,
  output logic             ds_ack,
  input  logic [XLEN-1:0]  ex_mem_result,
  input  logic [1:0]       ex_mem_op,
  input  logic [1:0]       ex_mem_size,
  input  logic             ex_mem_unsigned,
  input  logic [XLEN-1:0]  ex_mem_data,
  input  logic [4:0]       ex_mem_wb_rsd,
  output logic             us_rdy,
  input  logic             us_ack,
  riscv_mem_lsu_if.master  data_bif,
  output logic [XLEN-1:0]  mem_wb_data,
  output logic [4:0]       mem_wb_rsd,
  output logic             mem_wb_load,
  output logic             mem_wb_exc
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    HOLD
  } state_t;

  state_t state, nxt;

  logic [OFF_W-1:0]  off, off_q;
  logic [3:0]        amask;
  logic              is_ld, is_st, is_mem, mis, acc;
  logic [7:0]        bm;
  logic [STRB_W-1:0] wm;
  logic [XLEN-1:0]   wd, sh, tmp, ld;
  logic signed [XLEN-1:0] sx;
  logic [6:0]        sa;
  logic [1:0]        size_q;
  logic              uns_q, ld_q;

  // Decode the incoming op: type, alignment, byte lanes and write data.
  always_comb begin
    off    = ex_mem_result[OFF_W-1:0];
    amask  = 4'((5'd1 << ex_mem_size) - 5'd1);
    is_ld  = (ex_mem_op == 2'b01);
    is_st  = (ex_mem_op == 2'b10);
    is_mem = is_ld | is_st;
    mis    = (|(4'(off) & amask))
           | ((ex_mem_size == 2'd3) && (XLEN == 32));
    case (ex_mem_size)
      2'd0:    bm = 8'h01;
      2'd1:    bm = 8'h03;
      2'd2:    bm = 8'h0F;
      default: bm = 8'hFF;
    endcase
    wm = STRB_W'(bm) << off;
    wd = ex_mem_data << {off, 3'b000};
  end

  // Handshake and next-state selection.
  always_comb begin
    ds_ack = (state == IDLE) | ((state == HOLD) & us_ack);
    acc    = ds_rdy & ds_ack;
    nxt    = state;
    case (state)
      IDLE: if (acc) nxt = (is_mem & ~mis) ? BUS : HOLD;
      BUS:  if (data_bif.ack) nxt = HOLD;
      HOLD: begin
        if (acc) nxt = (is_mem & ~mis) ? BUS : HOLD;
        else if (us_ack) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Pick the addressed lane out of rdata and sign/zero extend it.
  always_comb begin
    sh  = data_bif.rdata >> {off_q, 3'b000};
    sa  = 7'(XLEN) - (7'd8 << size_q);
    tmp = sh << sa;
    sx  = $signed(tmp) >>> sa;
    ld  = uns_q ? (tmp >> sa) : sx;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  // Registered bus request, result bundle and latched access info.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_bif.req   <= 1'b0;
      data_bif.addr  <= '0;
      data_bif.rnw   <= 1'b0;
      data_bif.wmask <= '0;
      data_bif.wdata <= '0;
      us_rdy         <= 1'b0;
      mem_wb_data    <= '0;
      mem_wb_rsd     <= '0;
      mem_wb_load    <= 1'b0;
      mem_wb_exc     <= 1'b0;
      off_q          <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      ld_q           <= 1'b0;
    end else begin
      data_bif.req <= (nxt == BUS);
      us_rdy       <= (nxt == HOLD);
      if (acc) begin
        mem_wb_rsd <= ex_mem_wb_rsd;
        if (is_mem & ~mis) begin
          data_bif.addr  <= ex_mem_result;
          data_bif.rnw   <= is_ld;
          data_bif.wmask <= is_st ? wm : '0;
          data_bif.wdata <= wd;
          off_q          <= off;
          size_q         <= ex_mem_size;
          uns_q          <= ex_mem_unsigned;
          ld_q           <= is_ld;
        end else begin
          mem_wb_data <= ex_mem_result;
          mem_wb_load <= 1'b0;
          mem_wb_exc  <= is_mem;
        end
      end else if ((state == BUS) && data_bif.ack) begin
        mem_wb_data <= ld_q ? ld : '0;
        mem_wb_load <= ld_q;
        mem_wb_exc  <= 1'b0;
      end
    end
  end
endmodule
